// File: rtl/sprite_rom_arb.sv
// -----------------------------------------------------------------------------
// sprite_rom_arb
// Round-robin burst arbiter that shares one synchronous sprite bitmap ROM
// (1-cycle read latency) between NREQ requesters (tile renderer, player
// sprite, box sprites, HUD). Only one requester owns the ROM at a time. A
// grant lasts for at most BURST_MAX reads, which is one 20-pixel sprite row.
// Each pixel goes back to its owner one cycle after the ROM address is driven.
//
// Optional feature macro: SPRITE_KEY_EN
//   defined   : rtransp flags returned pixels equal to the transparent key KEY
//   undefined : rtransp is tied low and no compare logic is built
//
// Ports
//   clock        in   1        system clock, rising edge
//   reset_n      in   1        asynchronous active-low reset
//   req          in   NREQ     per-requester read request (level)
//   last         in   NREQ     final beat of the requester's burst
//   addr         in   NREQ*AW  per-requester address, slice i = addr[i*AW +: AW]
//   gnt          out  NREQ     one-hot, beat accepted this cycle (combinational)
//   rom_address  out  AW       ROM address port
//   rom_q        in   DW       ROM data, valid the cycle after the address
//   rdata        out  DW       returned pixel (= rom_q)
//   rvalid       out  NREQ     one-hot, registered; owner of rdata
//   rtransp      out  1        rdata equals KEY (feature dependent)
// -----------------------------------------------------------------------------
module sprite_rom_arb #(
   parameter int              NREQ      = 4,
   parameter int              AW        = 9,
   parameter int              DW        = 8,
   parameter int              BURST_MAX = 20,
   parameter logic [DW-1:0]   KEY       = 8'd255
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      last,
   input  logic [NREQ*AW-1:0]   addr,
   output logic [NREQ-1:0]      gnt,
   output logic [AW-1:0]        rom_address,
   input  logic [DW-1:0]        rom_q,
   output logic [DW-1:0]        rdata,
   output logic [NREQ-1:0]      rvalid,
   output logic                 rtransp
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BURST_MAX + 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_owner;
   logic [IW-1:0]     r_ptr;
   logic [CW-1:0]     r_beat_cnt;
   logic [AW-1:0]     r_last_addr;
   logic [NREQ-1:0]   r_rvalid;

   logic [NREQ-1:0]   w_owner_oh;
   logic [AW-1:0]     w_owner_addr;
   logic              w_beat;
   logic              w_last_beat;
   logic              w_full;
   logic              w_release;
   logic [IW-1:0]     w_start;
   logic [NREQ-1:0]   w_cand;
   logic [IW-1:0]     w_pick;

   // First set bit of v scanning start+1, start+2, ... wrapping; start itself last.
   function automatic logic [IW-1:0] f_pick(input logic [NREQ-1:0] v,
                                            input logic [IW-1:0]   start);
      logic [IW-1:0] w_sel;
      int            idx;
      w_sel = start;
      // Scan from the farthest offset down so the nearest requester wins.
      for (int i = NREQ; i >= 1; i--) begin
         idx = (int'(start) + i) % NREQ;
         if (v[idx]) begin
            w_sel = IW'(idx);
         end else begin
            w_sel = w_sel;
         end
      end
      return w_sel;
   endfunction

   // Owner decode, beat/release detection and candidate set for re-arbitration.
   always_comb begin
      w_owner_oh          = '0;
      w_owner_oh[r_owner] = 1'b1;
      w_owner_addr        = addr[int'(r_owner)*AW +: AW];
      w_beat              = 1'b0;
      w_last_beat         = 1'b0;
      w_full              = 1'b0;
      w_release           = 1'b0;
      w_start             = r_ptr;
      if (r_state == ST_BUSY) begin
         w_beat      = req[r_owner];
         w_last_beat = req[r_owner] & last[r_owner];
         w_full      = req[r_owner] & (r_beat_cnt == CW'(BURST_MAX - 1));
         // Release on last beat, on burst cap, or when the owner abandons.
         w_release   = ~req[r_owner] | w_last_beat | w_full;
         w_start     = r_owner;
      end else begin
         w_start     = r_ptr;
      end
      // A burst that just finished with 'last' does not compete again this cycle;
      // a capped burst still requesting does (lowest priority).
      if (w_last_beat) begin
         w_cand = req & ~w_owner_oh;
      end else begin
         w_cand = req;
      end
      w_pick = f_pick(w_cand, w_start);
   end

   // Grant and ROM address: beats move the address, idle cycles re-read the last one.
   always_comb begin
      if (w_beat) begin
         gnt         = w_owner_oh;
         rom_address = w_owner_addr;
      end else begin
         gnt         = '0;
         rom_address = r_last_addr;
      end
   end

   // Arbitration FSM, burst counter, address history and read-valid pipeline.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_ptr       <= IW'(NREQ - 1);
         r_beat_cnt  <= '0;
         r_last_addr <= '0;
         r_rvalid    <= '0;
      end else begin
         r_rvalid <= gnt;
         case (r_state)
            ST_IDLE: begin
               if (|req) begin
                  r_state    <= ST_BUSY;
                  r_owner    <= w_pick;
                  r_ptr      <= w_pick;
                  r_beat_cnt <= '0;
               end else begin
                  r_state    <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (w_beat) begin
                  r_last_addr <= w_owner_addr;
               end
               if (w_release) begin
                  r_beat_cnt <= '0;
                  // Hand over directly to the next requester, no idle bubble.
                  if (|w_cand) begin
                     r_state <= ST_BUSY;
                     r_owner <= w_pick;
                     r_ptr   <= w_pick;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end else if (w_beat) begin
                  r_beat_cnt <= r_beat_cnt + CW'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign rvalid = r_rvalid;
   assign rdata  = rom_q;

`ifdef SPRITE_KEY_EN
   // Transparency flag for the compositor, only meaningful with valid data.
   assign rtransp = (|r_rvalid) & (rom_q == KEY);
`else
   logic w_unused_key;
   assign w_unused_key = ^KEY;
   assign rtransp      = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_rom_arb.sv
module tb_sprite_rom_arb;

   localparam int NREQ = 4;
   localparam int AW   = 9;
   localparam int DW   = 8;
   localparam int BMAX = 20;

   logic                clock = 1'b0;
   logic                reset_n;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     last;
   logic [NREQ*AW-1:0]  addr;
   logic [NREQ-1:0]     gnt;
   logic [AW-1:0]       rom_address;
   logic [DW-1:0]       rom_q;
   logic [DW-1:0]       rdata;
   logic [NREQ-1:0]     rvalid;
   logic                rtransp;

   always #5 clock = ~clock;

   sprite_rom_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .BURST_MAX(BMAX), .KEY(8'd255)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .last(last), .addr(addr),
      .gnt(gnt), .rom_address(rom_address), .rom_q(rom_q), .rdata(rdata),
      .rvalid(rvalid), .rtransp(rtransp)
   );

   // ROM contents and synchronous 1-cycle read
   logic [7:0] rom [512];
   always @(posedge clock) rom_q <= rom[rom_address];

   // Requester agents
   bit a_active  [NREQ];
   int a_base    [NREQ];
   int a_len     [NREQ];
   int a_sent    [NREQ];
   bit a_uselast [NREQ];

   // Reference model of the arbitration rules
   bit m_busy;
   int m_owner, m_ptr, m_cnt, m_last_addr;

   typedef struct {
      int              cyc;
      logic [NREQ-1:0] vec;
      logic [7:0]      data;
   } exp_t;
   exp_t sbq[$];
   exp_t e;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
      end
   endtask

   function automatic int pick(logic [NREQ-1:0] v, int start);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(start + k) % NREQ]) return (start + k) % NREQ;
      end
      return start;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = NREQ - 1; m_cnt = 0; m_last_addr = 0;
      for (int i = 0; i < NREQ; i++) a_active[i] = 0;
   endtask

   task automatic start_burst(int i, int base, int len, bit ul);
      a_active[i] = 1; a_base[i] = base; a_len[i] = len; a_sent[i] = 0; a_uselast[i] = ul;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req[i]  = a_active[i];
         last[i] = a_active[i] && a_uselast[i] && (a_sent[i] == a_len[i] - 1);
         if (a_active[i]) addr[i*AW +: AW] = AW'((a_base[i] + a_sent[i]) % 512);
         else             addr[i*AW +: AW] = AW'($urandom_range(0, 511));
      end
   endtask

   // One clock cycle: drive, compare grant/address against the model, queue read expectation
   task automatic step();
      logic [NREQ-1:0] exp_gnt, cand;
      int exp_addr, w;
      bit beat, lastbeat, rel;
      @(posedge clock);
      cyc++;
      #1;
      drive();
      #1;
      exp_gnt = '0; exp_addr = m_last_addr; beat = 0;
      if (m_busy && req[m_owner]) begin
         beat = 1;
         exp_gnt[m_owner] = 1'b1;
         exp_addr = (a_base[m_owner] + a_sent[m_owner]) % 512;
      end
      chk("gnt", 32'(gnt), 32'(exp_gnt));
      chk("rom_address", 32'(rom_address), exp_addr);
      sbq.push_back('{cyc, exp_gnt, beat ? rom[exp_addr] : 8'd0});
      if (!m_busy) begin
         if (req != '0) begin
            w = pick(req, m_ptr);
            m_owner = w; m_ptr = w; m_cnt = 0; m_busy = 1;
         end
      end else begin
         lastbeat = beat && last[m_owner];
         if (beat) begin
            m_last_addr = exp_addr;
            m_cnt++;
         end
         rel = !beat || lastbeat || (m_cnt == BMAX);
         if (rel) begin
            cand = req;
            if (lastbeat) cand[m_owner] = 1'b0;
            m_cnt = 0;
            if (cand != '0) begin
               w = pick(cand, m_owner);
               m_owner = w; m_ptr = w;
            end else begin
               m_busy = 0;
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (exp_gnt[i]) begin
            a_sent[i]++;
            if (a_sent[i] == a_len[i]) a_active[i] = 0;
         end
      end
   endtask

   function automatic bit any_active();
      for (int i = 0; i < NREQ; i++) if (a_active[i]) return 1;
      return 0;
   endfunction

   task automatic run_until_idle(int budget);
      int n = 0;
      while ((m_busy || any_active()) && n < budget) begin
         step();
         n++;
      end
      checks++;
      if (n >= budget) begin
         failures++;
         $display("FAIL idle_timeout cyc=%0d actual=%0d cycles expected below %0d", cyc, n, budget);
      end
      step();
      step();
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      req = '0; last = '0;
      #1;
      chk("reset_gnt", 32'(gnt), 32'd0);
      chk("reset_rvalid", 32'(rvalid), 32'd0);
      chk("reset_rom_address", 32'(rom_address), 32'd0);
      sbq.delete();
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   // Scoreboard monitor: consumes the expectation queued for the previous cycle
   always @(negedge clock) begin
      if (reset_n === 1'b1) begin
         while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            if (e.cyc == cyc - 1) begin
               chk("rvalid", 32'(rvalid), 32'(e.vec));
               if (e.vec != '0) chk("rdata", 32'(rdata), 32'(e.data));
`ifdef SPRITE_KEY_EN
               chk("rtransp", 32'(rtransp), 32'((e.vec != '0) && (e.data == 8'd255)));
`else
               chk("rtransp", 32'(rtransp), 32'd0);
`endif
            end
         end
      end
   end

   initial begin
      for (int i = 0; i < 512; i++) rom[i] = (i % 5 == 0) ? 8'd255 : 8'($urandom_range(0, 254));
      rom[0] = 8'd255;
      rom[9] = 8'd63;
      addr = '0;
      @(posedge clock);
      apply_reset();

      // Single 20-beat burst with last on the final beat
      start_burst(0, 0, 20, 1);
      run_until_idle(100);

      // Two requesters together: 0 first, 2 handed over without a bubble
      start_burst(0, 100, 5, 1);
      start_burst(2, 200, 4, 1);
      run_until_idle(100);

      // 25 beats with no last: forced release after 20, owner regranted
      start_burst(1, 300, 25, 0);
      run_until_idle(100);

      // Owner abandons after 7 beats while another requester waits
      start_burst(3, 400, 7, 0);
      step();
      start_burst(0, 50, 3, 1);
      run_until_idle(100);

      // Reset in the middle of a burst, then simultaneous 0 and 1
      start_burst(2, 10, 15, 1);
      for (int n = 0; n < 50 && a_sent[2] < 5; n++) step();
      chk("beats_before_reset", a_sent[2], 5);
      @(posedge clock);
      #3;
      apply_reset();
      start_burst(0, 20, 4, 1);
      start_burst(1, 30, 4, 1);
      run_until_idle(100);

      // Randomised traffic
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!a_active[i] && $urandom_range(0, 7) == 0)
               start_burst(i, $urandom_range(0, 511), $urandom_range(1, 25), 1'($urandom_range(0, 1)));
         end
         step();
      end
      run_until_idle(2000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
